window_loader: RTL and testbench
================================

# window_loader

Parametrised K×K sliding-window generator for the Sobel datapath, successor to the fixed 3×3 8-bit loader. It accepts a raster-order pixel stream under a valid/ready handshake and buffers K-1 image lines. It emits one fully populated K×K window, with the window-centre coordinates, for every interior pixel position. It sits between the pixel source and the gradient/convolution stage and stalls cleanly under downstream backpressure.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits
- IMG_W, 256, image width in pixels (≥ K)
- IMG_H, 256, image height in lines (≥ K)
- K, 3, window size; odd, 3..7
- COORD_W, derived: $clog2(max(IMG_W,IMG_H)), coordinate width

Ports:
- CLK  in  1  single clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- Sof  in  1  start-of-frame; qualified by InValid&InReady; marks the accepted pixel as (0,0)
- DataIn  in  DATA_W  pixel value
- InValid  in  1  DataIn valid
- InReady  out  1  block can accept a pixel this cycle
- Window  out  K*K*DATA_W  slice [(i*K+j)*DATA_W +: DATA_W] = pixel (top+i, left+j); slice 0 = top-left (oldest)
- OutValid  out  1  Window/coords valid
- OutReady  in  1  downstream accepts window
- Out_Row  out  COORD_W  row of window centre
- Out_Column  out  COORD_W  column of window centre
- isEnd  out  1  high with the last window of the frame

## Operation
- Accept = InValid & InReady. InReady = !OutValid | OutReady (combinational). No other stall source.
- On Accept: DataIn enters line buffer 0; each line buffer's output feeds the next (K-1 line buffers, each IMG_W deep). DataIn and the K-1 line-buffer outputs each shift into their own K-deep register row. The bottom window row is fed from DataIn; the top window row is fed from line buffer K-2.
- Input counters (row r, col c) track the accepted pixel. c wraps IMG_W-1 → 0 with r+1. r wraps IMG_H-1 → 0.
- Sof on an accepted pixel forces (r,c) = (0,0) for that pixel. Line-buffer contents are kept but are don't-care.
- A window is complete when the accepted pixel has r ≥ K-1 and c ≥ K-1. Only interior windows are produced; there is no border padding. Each frame yields (IMG_W-K+1)*(IMG_H-K+1) windows.
- Out_Row = r-(K-1)/2 and Out_Column = c-(K-1)/2 of the completing pixel.
- isEnd = OutValid & (r,c) of the completing pixel == (IMG_H-1, IMG_W-1).
- Windows that straddle a column wrap are never flagged valid. Stale left columns are don't-care for those windows.

## Timing
- Reset values: OutValid=0, isEnd=0, Out_Row=0, Out_Column=0, Window=0, r=c=0. InReady=1 in the cycle after reset.
- Line-buffer RAM/registers are not reset. Validity comes only from the counters.
- Latency: a window is presented with OutValid=1 in the cycle after the Accept of its completing pixel.
- OutValid & !OutReady: Window, coordinates, isEnd and OutValid are held stable. InReady=0, and no counter or buffer advances.
- OutValid & OutReady & InValid in the same cycle: the current window retires and the next pixel is accepted.
- Accept of a non-completing pixel clears OutValid next cycle (once the current window retires).
- InValid low: nothing shifts. A held window remains until taken.
- Reset mid-frame: the next accepted pixel is (0,0). No window is emitted until K-1 full lines plus K pixels are re-accepted.
- Reset has priority over Accept and Sof in the same cycle.

## Structure
- Package sobel_pkg holds the default DATA_W/IMG_W/IMG_H/K, the clog2 coordinate-width helper, and the window-slice index function.
- Sub-module line_buffer (DATA_W, DEPTH) is an enable-gated delay line with a circular pointer and no reset on storage. It is instantiated K-1 times via generate.
- The K×K register array and counters are generate loops in window_loader.

## Test plan
- Basic frame, IMG_W=5, IMG_H=4, K=3, pixel = 16*r+c, InValid and OutReady held high:
  - First OutValid one cycle after the 13th accept.
  - Window = {00,01,02,10,11,12,20,21,22}, centre (1,1).
  - Exactly 6 windows are produced.
  - The last window has centre (2,3) with isEnd=1.
- Backpressure: drop OutReady for 4 cycles while the first window is valid. Window and coords stay constant, InReady=0, and the pixel presented is accepted only after OutReady returns. The window sequence matches the no-stall run.
- Input bubbles: toggle InValid randomly. The window sequence and coordinates are identical to the basic run.
- Reset mid-frame: assert Reset after 9 accepts, then stream a full frame. OutValid=0 until the 13th post-reset accept, and the windows match the basic run.
- Sof resync: assert Sof on the 7th pixel of a frame. That pixel is treated as (0,0), and the first window appears 12 accepts later with centre (1,1).
- K=5, IMG_W=IMG_H=6: exactly 4 windows. The first window has centre (2,2) and slice 0 = pixel (0,0).

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared defaults and helpers for the Sobel front end.
// Coordinate width and window slice indexing live here.
package sobel_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_IMG_W  = 256;
   localparam int DEF_IMG_H  = 256;
   localparam int DEF_K      = 3;

   function automatic int coord_w(input int w, input int h);
      return $clog2((w > h) ? w : h);
   endfunction

   function automatic int win_idx(input int i, input int j, input int k);
      return i * k + j;
   endfunction

endpackage

// File: rtl/window_loader_line_buffer.sv
// Enable-gated delay line of DEPTH samples on a circular pointer.
// Storage is not reset; only the pointer is.
module line_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  ptr_q;
   logic [PTR_W-1:0]  ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (en) begin
         ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         mem[ptr_q] <= din;
      end
   end

   // The slot about to be overwritten holds the sample from DEPTH accepts ago.
   assign dout = mem[ptr_q];

endmodule

// File: rtl/window_loader.sv
// K x K sliding-window generator over a raster pixel stream.
// Emits one window per interior pixel with its centre coordinates.
module window_loader
   import sobel_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int IMG_W   = DEF_IMG_W,
   parameter int IMG_H   = DEF_IMG_H,
   parameter int K       = DEF_K,
   parameter int COORD_W = coord_w(IMG_W, IMG_H)
) (
   input  logic                    CLK,
   input  logic                    Reset,
   input  logic                    Sof,
   input  logic [DATA_W-1:0]       DataIn,
   input  logic                    InValid,
   output logic                    InReady,
   output logic [K*K*DATA_W-1:0]   Window,
   output logic                    OutValid,
   input  logic                    OutReady,
   output logic [COORD_W-1:0]      Out_Row,
   output logic [COORD_W-1:0]      Out_Column,
   output logic                    isEnd
);

   localparam logic [COORD_W-1:0] LAST_C = COORD_W'(IMG_W - 1);
   localparam logic [COORD_W-1:0] LAST_R = COORD_W'(IMG_H - 1);
   localparam logic [COORD_W-1:0] KM1    = COORD_W'(K - 1);
   localparam logic [COORD_W-1:0] HALF   = COORD_W'((K - 1) / 2);

   logic                                accept;
   logic                                complete;
   logic [K-1:0][DATA_W-1:0]            chain;
   logic [K-1:0][K-1:0][DATA_W-1:0]     win_q;
   logic [K-1:0][K-1:0][DATA_W-1:0]     win_d;
   logic [COORD_W-1:0]                  row_q, row_d;
   logic [COORD_W-1:0]                  col_q, col_d;
   logic [COORD_W-1:0]                  pix_r, pix_c;
   logic [COORD_W-1:0]                  orow_q, orow_d;
   logic [COORD_W-1:0]                  ocol_q, ocol_d;
   logic                                valid_q, valid_d;
   logic                                end_q, end_d;

   assign InReady = !valid_q || OutReady;
   assign accept  = InValid && InReady;

   // chain[n] is the pixel accepted n full lines ago.
   assign chain[0] = DataIn;

   for (genvar g = 0; g < K - 1; g++) begin : g_lb
      line_buffer #(
         .DATA_W (DATA_W),
         .DEPTH  (IMG_W)
      ) u_lb (
         .clk  (CLK),
         .rst  (Reset),
         .en   (accept),
         .din  (chain[g]),
         .dout (chain[g+1])
      );
   end

   always_comb begin
      pix_r    = Sof ? '0 : row_q;
      pix_c    = Sof ? '0 : col_q;
      complete = (pix_r >= KM1) && (pix_c >= KM1);
      row_d    = row_q;
      col_d    = col_q;
      orow_d   = orow_q;
      ocol_d   = ocol_q;
      valid_d  = valid_q && !OutReady;
      end_d    = end_q && !OutReady;
      win_d    = win_q;
      if (accept) begin
         if (pix_c == LAST_C) begin
            col_d = '0;
            row_d = (pix_r == LAST_R) ? '0 : pix_r + 1'b1;
         end else begin
            col_d = pix_c + 1'b1;
            row_d = pix_r;
         end
         valid_d = complete;
         end_d   = complete && (pix_r == LAST_R) && (pix_c == LAST_C);
         if (complete) begin
            orow_d = pix_r - HALF;
            ocol_d = pix_c - HALF;
         end
         for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
               win_d[i][j] = win_q[i][j+1];
            end
            win_d[i][K-1] = chain[K-1-i];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         row_q   <= '0;
         col_q   <= '0;
         orow_q  <= '0;
         ocol_q  <= '0;
         valid_q <= 1'b0;
         end_q   <= 1'b0;
         win_q   <= '0;
      end else begin
         row_q   <= row_d;
         col_q   <= col_d;
         orow_q  <= orow_d;
         ocol_q  <= ocol_d;
         valid_q <= valid_d;
         end_q   <= end_d;
         win_q   <= win_d;
      end
   end

   for (genvar i = 0; i < K; i++) begin : g_row
      for (genvar j = 0; j < K; j++) begin : g_col
         assign Window[win_idx(i, j, K)*DATA_W +: DATA_W] = win_q[i][j];
      end
   end

   assign OutValid   = valid_q;
   assign Out_Row    = orow_q;
   assign Out_Column = ocol_q;
   assign isEnd      = end_q;

endmodule

// File: tb/tb_window_loader.sv
// Scoreboard bench for window_loader: K=3 5x4 and K=5 6x6 instances.
// Stimulus pushes expected windows; negedge monitors pop and compare.
module tb_window_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, sof;
   logic [7:0]   din;
   logic         iv_a, ir_a, ov_a, or_a, end_a;
   logic [71:0]  win_a;
   logic [2:0]   row_a, col_a;
   logic         iv_b, ir_b, ov_b, or_b, end_b;
   logic [199:0] win_b;
   logic [2:0]   row_b, col_b;

   window_loader #(
      .DATA_W(8), .IMG_W(5), .IMG_H(4), .K(3)
   ) dut_a (
      .CLK(clk), .Reset(rst), .Sof(sof), .DataIn(din),
      .InValid(iv_a), .InReady(ir_a), .Window(win_a),
      .OutValid(ov_a), .OutReady(or_a), .Out_Row(row_a),
      .Out_Column(col_a), .isEnd(end_a)
   );

   window_loader #(
      .DATA_W(8), .IMG_W(6), .IMG_H(6), .K(5)
   ) dut_b (
      .CLK(clk), .Reset(rst), .Sof(sof), .DataIn(din),
      .InValid(iv_b), .InReady(ir_b), .Window(win_b),
      .OutValid(ov_b), .OutReady(or_b), .Out_Row(row_b),
      .Out_Column(col_b), .isEnd(end_b)
   );

   typedef struct {
      logic [199:0] win;
      int           row;
      int           col;
      logic         last;
   } exp_t;

   localparam logic [71:0] FIRST_A = 72'h22_21_20_12_11_10_02_01_00;

   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;
   int   tests = 0;
   int   fails = 0;
   int   mr[2], mc[2], nwin[2];
   bit   lat_pend[2];
   logic lat_exp[2];

   task automatic chk(input string nm, input logic [199:0] act,
                      input logic [199:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Stimulus pixel value is 16*row+col, so a window is known from its centre.
   function automatic logic [199:0] exp_win(input int r, input int c,
                                            input int k);
      logic [199:0] w;
      int h;
      w = '0;
      h = (k - 1) / 2;
      for (int i = 0; i < k; i++)
         for (int j = 0; j < k; j++)
            w[(i*k+j)*8 +: 8] = 8'(16 * (r - h + i) + (c - h + j));
      return w;
   endfunction

   always @(negedge clk) begin
      if (lat_pend[0]) begin
         chk("latency_a", 200'(ov_a), 200'(lat_exp[0]));
         lat_pend[0] = 1'b0;
      end
      if (ov_a && or_a) begin
         if (q_a.size() == 0) begin
            chk("spurious_win_a", 200'(ov_a), 200'(0));
         end else begin
            e_a = q_a.pop_front();
            chk("win_a", 200'(win_a), e_a.win);
            chk("row_a", 200'(row_a), 200'(e_a.row));
            chk("col_a", 200'(col_a), 200'(e_a.col));
            chk("isend_a", 200'(end_a), 200'(e_a.last));
         end
         nwin[0]++;
      end
   end

   always @(negedge clk) begin
      if (lat_pend[1]) begin
         chk("latency_b", 200'(ov_b), 200'(lat_exp[1]));
         lat_pend[1] = 1'b0;
      end
      if (ov_b && or_b) begin
         if (q_b.size() == 0) begin
            chk("spurious_win_b", 200'(ov_b), 200'(0));
         end else begin
            e_b = q_b.pop_front();
            chk("win_b", win_b, e_b.win);
            chk("row_b", 200'(row_b), 200'(e_b.row));
            chk("col_b", 200'(col_b), 200'(e_b.col));
            chk("isend_b", 200'(end_b), 200'(e_b.last));
         end
         nwin[1]++;
      end
   end

   task automatic send(input int s, input bit first, input int gap);
      int   w, h, k, hk;
      bit   acc, comp;
      exp_t e;
      w  = s ? 6 : 5;
      h  = s ? 6 : 4;
      k  = s ? 5 : 3;
      hk = (k - 1) / 2;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk);
         #1;
      end
      if (first) begin
         mr[s] = 0;
         mc[s] = 0;
      end
      din = 8'(16 * mr[s] + mc[s]);
      sof = first;
      if (s != 0) iv_b = 1'b1;
      else iv_a = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) begin
         @(negedge clk);
         acc = (s != 0) ? ir_b : ir_a;
         @(posedge clk);
         #1;
      end
      iv_a = 1'b0;
      iv_b = 1'b0;
      sof  = 1'b0;
      if (!acc) begin
         chk("accept_timeout", 200'(acc), 200'(1));
         return;
      end
      comp = (mr[s] >= k - 1) && (mc[s] >= k - 1);
      if (comp) begin
         e.win  = exp_win(mr[s] - hk, mc[s] - hk, k);
         e.row  = mr[s] - hk;
         e.col  = mc[s] - hk;
         e.last = (mr[s] == h - 1) && (mc[s] == w - 1);
         if (s != 0) q_b.push_back(e);
         else q_a.push_back(e);
      end
      lat_exp[s]  = comp;
      lat_pend[s] = 1'b1;
      if (mc[s] == w - 1) begin
         mc[s] = 0;
         mr[s] = (mr[s] == h - 1) ? 0 : mr[s] + 1;
      end else begin
         mc[s]++;
      end
   endtask

   task automatic stall_a();
      din  = 8'(16 * mr[0] + mc[0]);
      iv_a = 1'b1;
      or_a = 1'b0;
      repeat (4) begin
         @(posedge clk);
         #1;
         chk("stall_valid", 200'(ov_a), 200'(1));
         chk("stall_inready", 200'(ir_a), 200'(0));
         chk("stall_win", 200'(win_a), 200'(FIRST_A));
         chk("stall_row", 200'(row_a), 200'(1));
         chk("stall_col", 200'(col_a), 200'(1));
      end
      or_a = 1'b1;
   endtask

   task automatic frame(input int s, input int gap_max, input bit stall);
      int w, h, k, n0, qn;
      w  = s ? 6 : 5;
      h  = s ? 6 : 4;
      k  = s ? 5 : 3;
      n0 = nwin[s];
      for (int n = 0; n < w * h; n++) begin
         send(s, n == 0, (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
         if (n == (k - 1) * w + k - 1) begin
            chk("first_valid", 200'((s != 0) ? ov_b : ov_a), 200'(1));
            chk("first_row", 200'((s != 0) ? row_b : row_a), 200'((k - 1) / 2));
            chk("first_col", 200'((s != 0) ? col_b : col_a), 200'((k - 1) / 2));
            chk("first_slice0", 200'((s != 0) ? win_b[7:0] : win_a[7:0]), 200'(0));
            if (s == 0) chk("first_win_a", 200'(win_a), 200'(FIRST_A));
            if (stall) stall_a();
         end
      end
      repeat (3) @(posedge clk);
      #1;
      qn = (s != 0) ? q_b.size() : q_a.size();
      chk("win_count", 200'(nwin[s] - n0), 200'((w - k + 1) * (h - k + 1)));
      chk("queue_empty", 200'(qn), 200'(0));
   endtask

   task automatic reset_checks();
      chk("rst_outvalid", 200'(ov_a), 200'(0));
      chk("rst_isend", 200'(end_a), 200'(0));
      chk("rst_row", 200'(row_a), 200'(0));
      chk("rst_col", 200'(col_a), 200'(0));
      chk("rst_window", 200'(win_a), 200'(0));
      chk("rst_inready", 200'(ir_a), 200'(1));
      chk("rst_outvalid_b", 200'(ov_b), 200'(0));
      chk("rst_window_b", win_b, 200'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst  = 1'b1;
      sof  = 1'b0;
      din  = '0;
      iv_a = 1'b0;
      iv_b = 1'b0;
      or_a = 1'b1;
      or_b = 1'b1;
      for (int s = 0; s < 2; s++) begin
         mr[s] = 0;
         mc[s] = 0;
         nwin[s] = 0;
         lat_pend[s] = 1'b0;
         lat_exp[s] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      reset_checks();

      frame(0, 0, 1'b0);
      frame(0, 0, 1'b1);
      frame(0, 2, 1'b0);

      for (int n = 0; n < 9; n++) send(0, n == 0, 0);
      rst  = 1'b1;
      sof  = 1'b1;
      iv_a = 1'b1;
      din  = 8'hAA;
      @(posedge clk);
      #1;
      rst  = 1'b0;
      sof  = 1'b0;
      iv_a = 1'b0;
      mr[0] = 0;
      mc[0] = 0;
      reset_checks();
      frame(0, 0, 1'b0);

      for (int n = 0; n < 6; n++) send(0, 1'b0, 0);
      frame(0, 0, 1'b0);

      frame(1, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
